demux_router_hs: RTL

- Parametrised, registered 1-to-NCH demultiplexer for WIDTH-bit words. Successor to the fixed 16-bit 1-to-8 combinational demux.
- Adds a valid/ready handshake on the input and on every output channel.
- Each output channel has a one-entry holding register, plus a broadcast mode, invalid-select detection and a transfer counter.
- Sits between a single producer and up to NCH independent consumers, for example register-bank or device fan-out.

---
 rtl/demux_router_hs.sv | 91 +++++++++
 1 files changed

// File: rtl/demux_router_hs.sv
// rtl/demux_router_hs.sv - registered 1-to-NCH demux with per-channel valid/ready holding slots
module demux_router_hs #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SELW-1:0]        in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic                   err_sel,
    output logic [CNTW-1:0]        acc_count
);

    localparam logic [SELW:0] NCH_W = NCH[SELW:0];

    logic [NCH-1:0][WIDTH-1:0] data_q, data_d;
    logic [NCH-1:0]            valid_q, valid_d;
    logic                      err_q, err_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;

    logic [NCH-1:0] avail;
    logic [NCH-1:0] sel_oh;
    logic [NCH-1:0] load;
    logic           sel_ok;
    logic           xfer;

    assign avail  = ~valid_q | out_ready;
    assign sel_ok = ({1'b0, in_sel} < NCH_W);

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_sel == i[SELW-1:0]) sel_oh[i] = 1'b1;
        end
    end

    // Out-of-range selects are always accepted so the producer never deadlocks on them.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast)    in_ready = &avail;
        else if (sel_ok) in_ready = |(avail & sel_oh);
    end

    assign xfer = in_valid && in_ready;
    assign load = (xfer && in_bcast) ? {NCH{1'b1}} :
                  (xfer && sel_ok)   ? sel_oh : '0;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
                data_d[i]  = in_data;
                valid_d[i] = 1'b1;
            end else if (valid_q[i] && out_ready[i]) begin
                data_d[i]  = '0;
                valid_d[i] = 1'b0;
            end
        end
        err_d = err_q | (xfer && !in_bcast && !sel_ok);
        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, (xfer && (in_bcast || sel_ok))};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_sel   = err_q;
    assign acc_count = cnt_q;

endmodule
